// File: rtl/sa3x3_conv_seq_pkg.sv
// sa3x3_conv_seq_pkg: shared state encodings, geometry constants and flat-index helper
package sa3x3_conv_seq_pkg;
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_FEED  = 3'd2,
    S_DRAIN = 3'd3,
    S_CAPT  = 3'd4,
    S_DONE  = 3'd5
  } state_e;
  localparam int IMG_N      = 4;
  localparam int KER_N      = 3;
  localparam int FEED_BEATS = 5;
  localparam int N_WIN      = 4;
  function automatic int flat_off(int n, int i, int j, int dw);
    return (n * i + j) * dw;
  endfunction
endpackage

// File: rtl/sa3x3_lane_mux.sv
// sa3x3_lane_mux: picks the skewed (data, weight) pair for one array lane at beat t
module sa3x3_lane_mux
  import sa3x3_conv_seq_pkg::*;
#(
  parameter int DW   = 8,
  parameter int LANE = 0
) (
  input  logic [IMG_N*IMG_N*DW-1:0] a_i,
  input  logic [KER_N*KER_N*DW-1:0] b_i,
  input  logic                      r_i,
  input  logic                      c_i,
  input  logic [2:0]                t_i,
  output logic [DW-1:0]             din_o,
  output logic [DW-1:0]             win_o
);
  localparam int AW = $clog2(IMG_N*IMG_N*DW);
  localparam int BW = $clog2(KER_N*KER_N*DW);
  logic [2:0]    d;
  logic          hit;
  int            j;
  logic [AW-1:0] ai;
  logic [BW-1:0] bi;
  // j is forced to 0 off-window so the selects never leave the operand range
  always_comb begin
    d     = t_i - 3'(LANE);
    hit   = (t_i >= 3'(LANE)) && (d <= 3'd2);
    j     = hit ? int'(d) : 0;
    ai    = AW'(flat_off(IMG_N, int'(r_i) + LANE, int'(c_i) + j, DW));
    bi    = BW'(flat_off(KER_N, LANE, j, DW));
    din_o = hit ? a_i[ai +: DW] : '0;
    win_o = hit ? b_i[bi +: DW] : '0;
  end
endmodule

// File: rtl/sa3x3_conv_seq.sv
// sa3x3_conv_seq: sequences four 3x3 windows of a 4x4 image through the shared systolic array
module sa3x3_conv_seq
  import sa3x3_conv_seq_pkg::*;
#(
  parameter int DW        = 8,
  parameter int DRAIN_CYC = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      en_i,
  input  logic                      start_i,
  input  logic [IMG_N*IMG_N*DW-1:0] a_flat_i,
  input  logic [KER_N*KER_N*DW-1:0] b_flat_i,
  input  logic [DW-1:0]             sa_out_i,
  output logic                      sa_clear_o,
  output logic [DW-1:0]             sa_din0_o,
  output logic [DW-1:0]             sa_din1_o,
  output logic [DW-1:0]             sa_din2_o,
  output logic [DW-1:0]             sa_win0_o,
  output logic [DW-1:0]             sa_win1_o,
  output logic [DW-1:0]             sa_win2_o,
  output logic [DW-1:0]             c00_o,
  output logic [DW-1:0]             c01_o,
  output logic [DW-1:0]             c10_o,
  output logic [DW-1:0]             c11_o,
  output logic [3:0]                c_valid_o,
  output logic                      busy_o,
  output logic                      done_o,
  output logic [2:0]                state_o
);
  localparam int DCW = DRAIN_CYC > 1 ? $clog2(DRAIN_CYC) : 1;
  state_e                    state_q, state_d;
  logic [1:0]                widx_q, widx_d;
  logic [2:0]                t_q, t_d;
  logic [DCW-1:0]            dc_q, dc_d;
  logic [IMG_N*IMG_N*DW-1:0] a_q, a_d;
  logic [KER_N*KER_N*DW-1:0] b_q, b_d;
  logic [2:0][DW-1:0]        din_q, din_d, wl_q, wl_d, md, mw;
  logic [3:0][DW-1:0]        c_q, c_d;
  logic [3:0]                cv_q, cv_d;
  logic                      clr_q, clr_d, busy_q, busy_d, done_q, done_d;
  for (genvar i = 0; i < 3; i++) begin : g_lane
    sa3x3_lane_mux #(.DW(DW), .LANE(i)) u_mux (
      .a_i   (a_q),
      .b_i   (b_q),
      .r_i   (widx_q[1]),
      .c_i   (widx_q[0]),
      .t_i   (t_d),
      .din_o (md[i]),
      .win_o (mw[i])
    );
  end
  always_comb begin
    state_d = state_q;
    widx_d  = widx_q;
    t_d     = t_q;
    dc_d    = dc_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    cv_d    = cv_q;
    case (state_q)
      S_IDLE: if (start_i) begin
        a_d     = a_flat_i;
        b_d     = b_flat_i;
        widx_d  = '0;
        cv_d    = '0;
        state_d = S_CLEAR;
      end
      S_CLEAR: begin
        t_d     = '0;
        state_d = S_FEED;
      end
      S_FEED: begin
        t_d     = t_q == 3'(FEED_BEATS-1) ? t_q : t_q + 3'd1;
        dc_d    = '0;
        state_d = t_q == 3'(FEED_BEATS-1) ? S_DRAIN : S_FEED;
      end
      S_DRAIN: begin
        dc_d    = dc_q + DCW'(1);
        state_d = dc_q == DCW'(DRAIN_CYC-1) ? S_CAPT : S_DRAIN;
      end
      S_CAPT: begin
        c_d[widx_q]  = sa_out_i;
        cv_d[widx_q] = 1'b1;
        widx_d       = widx_q + 2'd1;
        state_d      = widx_q == 2'(N_WIN-1) ? S_DONE : S_CLEAR;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // outputs are registered from the next state so they line up with state_o
    din_d  = state_d == S_FEED ? md : '0;
    wl_d   = state_d == S_FEED ? mw : '0;
    clr_d  = state_d == S_CLEAR;
    busy_d = state_d != S_IDLE;
    done_d = state_d == S_DONE;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      widx_q  <= '0;
      t_q     <= '0;
      dc_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      din_q   <= '0;
      wl_q    <= '0;
      c_q     <= '0;
      cv_q    <= '0;
      clr_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else if (en_i) begin
      state_q <= state_d;
      widx_q  <= widx_d;
      t_q     <= t_d;
      dc_q    <= dc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      din_q   <= din_d;
      wl_q    <= wl_d;
      c_q     <= c_d;
      cv_q    <= cv_d;
      clr_q   <= clr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end
  assign sa_clear_o = clr_q;
  assign sa_din0_o  = din_q[0];
  assign sa_din1_o  = din_q[1];
  assign sa_din2_o  = din_q[2];
  assign sa_win0_o  = wl_q[0];
  assign sa_win1_o  = wl_q[1];
  assign sa_win2_o  = wl_q[2];
  assign c00_o      = c_q[0];
  assign c01_o      = c_q[1];
  assign c10_o      = c_q[2];
  assign c11_o      = c_q[3];
  assign c_valid_o  = cv_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign state_o    = state_q;
endmodule
